// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control FSM with req/ack memory handshake and retired-instruction counter
// Define MC_CTRL_TRAP_EN to halt on illegal instructions; otherwise they retire as NOPs.
module mc_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             pc_we,
  output logic             ir_we,
  output logic             rf_we,
  output logic [1:0]       reg_dst_sel,
  output logic             alu_src_sel,
  output logic [1:0]       wd_sel,
  output logic [1:0]       npc_sel,
  output logic             ext_op,
  output logic [2:0]       alu_op,
  output logic             trap,
  output logic [CNT_W-1:0] instr_cnt
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXE    = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;
  state_t state, state_nxt;
  logic is_r, is_addu, is_subu, is_jr, is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal, legal, retire;
  assign is_r    = opcode == 6'b000000;
  assign is_addu = is_r && funct == 6'b100001;
  assign is_subu = is_r && funct == 6'b100011;
  assign is_jr   = is_r && funct == 6'b001000;
  assign is_ori  = opcode == 6'b001101;
  assign is_lw   = opcode == 6'b100011;
  assign is_sw   = opcode == 6'b101011;
  assign is_beq  = opcode == 6'b000100;
  assign is_lui  = opcode == 6'b001111;
  assign is_j    = opcode == 6'b000010;
  assign is_jal  = opcode == 6'b000011;
  assign legal   = is_addu | is_subu | is_jr | is_ori | is_lw | is_sw | is_beq | is_lui | is_j | is_jal;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      instr_cnt <= '0;
    end else begin
      state     <= state_nxt;
      instr_cnt <= retire ? instr_cnt + 1'b1 : instr_cnt;
    end
  end
  // Outputs are forced low while reset is high so an in-flight mem_req drops immediately.
  always_comb begin
    state_nxt   = state;
    retire      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    pc_we       = 1'b0;
    ir_we       = 1'b0;
    rf_we       = 1'b0;
    reg_dst_sel = 2'b00;
    alu_src_sel = 1'b0;
    wd_sel      = 2'b00;
    npc_sel     = 2'b00;
    ext_op      = 1'b0;
    alu_op      = 3'd0;
    trap        = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          mem_req   = 1'b1;
          ir_we     = mem_ack;
          pc_we     = mem_ack;
          state_nxt = mem_ack ? DECODE : FETCH;
        end
        DECODE: begin
          if (is_j || is_jal || is_jr) begin
            pc_we       = 1'b1;
            npc_sel     = is_jr ? 2'b11 : 2'b10;
            rf_we       = is_jal;
            reg_dst_sel = is_jal ? 2'b10 : 2'b00;
            wd_sel      = is_jal ? 2'b10 : 2'b00;
            retire      = 1'b1;
            state_nxt   = FETCH;
          end else begin
`ifdef MC_CTRL_TRAP_EN
            state_nxt = legal ? EXE : TRAP;
`else
            retire    = !legal;
            state_nxt = legal ? EXE : FETCH;
`endif
          end
        end
        EXE: begin
          alu_op      = is_subu || is_beq ? 3'd1 : is_ori ? 3'd2 : is_lui ? 3'd3 : 3'd0;
          alu_src_sel = is_ori | is_lui | is_lw | is_sw;
          ext_op      = is_lw | is_sw | is_beq;
          npc_sel     = is_beq ? 2'b01 : 2'b00;
          pc_we       = is_beq & alu_zero;
          retire      = is_beq;
          state_nxt   = is_beq ? FETCH : (is_lw || is_sw) ? MEM : WB;
        end
        MEM: begin
          mem_req   = 1'b1;
          mem_we    = is_sw;
          retire    = mem_ack & is_sw;
          state_nxt = !mem_ack ? MEM : is_sw ? FETCH : WB;
        end
        WB: begin
          rf_we       = 1'b1;
          reg_dst_sel = is_r ? 2'b01 : 2'b00;
          wd_sel      = is_lw ? 2'b01 : 2'b00;
          retire      = 1'b1;
          state_nxt   = FETCH;
        end
`ifdef MC_CTRL_TRAP_EN
        TRAP: trap = 1'b1;
`endif
        default: state_nxt = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed checks of per-cycle control outputs and instruction counting for mc_ctrl_fsm.
module tb_mc_ctrl_fsm;
  logic clk = 1'b0, reset = 1'b1, alu_zero = 1'b0, mem_ack = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic mem_req, mem_we, pc_we, ir_we, rf_we, alu_src_sel, ext_op, trap;
  logic [1:0] reg_dst_sel, wd_sel, npc_sel;
  logic [2:0] alu_op;
  logic [31:0] instr_cnt;
  logic mem_req4, mem_we4, pc_we4, ir_we4, rf_we4, alu_src_sel4, ext_op4, trap4;
  logic [1:0] reg_dst_sel4, wd_sel4, npc_sel4;
  logic [2:0] alu_op4;
  logic [3:0] instr_cnt4;
  logic [16:0] outs;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  assign outs = {mem_req, mem_we, pc_we, ir_we, rf_we, reg_dst_sel, alu_src_sel, wd_sel, npc_sel, ext_op, alu_op, trap};
  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we),
    .reg_dst_sel(reg_dst_sel), .alu_src_sel(alu_src_sel), .wd_sel(wd_sel), .npc_sel(npc_sel),
    .ext_op(ext_op), .alu_op(alu_op), .trap(trap), .instr_cnt(instr_cnt)
  );
  mc_ctrl_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero), .mem_ack(mem_ack),
    .mem_req(mem_req4), .mem_we(mem_we4), .pc_we(pc_we4), .ir_we(ir_we4), .rf_we(rf_we4),
    .reg_dst_sel(reg_dst_sel4), .alu_src_sel(alu_src_sel4), .wd_sel(wd_sel4), .npc_sel(npc_sel4),
    .ext_op(ext_op4), .alu_op(alu_op4), .trap(trap4), .instr_cnt(instr_cnt4)
  );
  function automatic logic [16:0] mk(input logic req, we, pc, ir, rf, input logic [1:0] rd, input logic src,
                                     input logic [1:0] wd, npc, input logic ext, input logic [2:0] alu, input logic trp);
    return {req, we, pc, ir, rf, rd, src, wd, npc, ext, alu, trp};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic ins(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask
  // Drive one cycle: inputs set after the edge, outputs checked mid-cycle.
  task automatic step(input string tag, input logic z, input logic ack, input logic [16:0] exp);
    alu_zero = z;
    mem_ack  = ack;
    #3;
    chk(tag, {15'd0, outs}, {15'd0, exp});
    @(posedge clk);
    #1;
  endtask
  logic [16:0] f_ack, f_wait, nil, wb_r, wb_i;
  initial begin
    f_ack  = mk(1,0,1,1,0,2'b00,0,2'b00,2'b00,0,3'd0,0);
    f_wait = mk(1,0,0,0,0,2'b00,0,2'b00,2'b00,0,3'd0,0);
    nil    = '0;
    wb_r   = mk(0,0,0,0,1,2'b01,0,2'b00,2'b00,0,3'd0,0);
    wb_i   = mk(0,0,0,0,1,2'b00,0,2'b00,2'b00,0,3'd0,0);
    @(posedge clk);
    #1;
    chk("reset_outs", {15'd0, outs}, 32'd0);
    chk("reset_cnt", instr_cnt, 32'd0);
    reset = 1'b0;
    ins(6'b000000, 6'b100001);
    step("addu_f", 0, 1, f_ack);
    step("addu_d", 0, 1, nil);
    step("addu_e", 0, 1, nil);
    step("addu_wb", 0, 1, wb_r);
    chk("cnt_addu", instr_cnt, 1);
    ins(6'b000000, 6'b100011);
    step("subu_f", 0, 1, f_ack);
    step("subu_d", 0, 1, nil);
    step("subu_e", 0, 1, mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,3'd1,0));
    step("subu_wb", 0, 1, wb_r);
    chk("cnt_subu", instr_cnt, 2);
    ins(6'b100011, 6'b000000);
    step("lw_f", 0, 1, f_ack);
    step("lw_d", 0, 1, nil);
    step("lw_e", 0, 1, mk(0,0,0,0,0,2'b00,1,2'b00,2'b00,1,3'd0,0));
    for (int i = 0; i < 4; i++) step("lw_mem", 0, i == 3, f_wait);
    step("lw_wb", 0, 1, mk(0,0,0,0,1,2'b00,0,2'b01,2'b00,0,3'd0,0));
    chk("cnt_lw", instr_cnt, 3);
    ins(6'b101011, 6'b000000);
    step("sw_f_wait", 0, 0, f_wait);
    step("sw_f", 0, 1, f_ack);
    step("sw_d", 0, 1, nil);
    step("sw_e", 0, 1, mk(0,0,0,0,0,2'b00,1,2'b00,2'b00,1,3'd0,0));
    step("sw_mem", 0, 1, mk(1,1,0,0,0,2'b00,0,2'b00,2'b00,0,3'd0,0));
    chk("cnt_sw", instr_cnt, 4);
    ins(6'b000100, 6'b000000);
    step("beq1_f", 1, 1, f_ack);
    step("beq1_d", 1, 1, nil);
    step("beq1_e", 1, 1, mk(0,0,1,0,0,2'b00,0,2'b00,2'b01,1,3'd1,0));
    step("beq0_f", 0, 1, f_ack);
    step("beq0_d", 0, 1, nil);
    step("beq0_e", 0, 1, mk(0,0,0,0,0,2'b00,0,2'b00,2'b01,1,3'd1,0));
    chk("cnt_beq", instr_cnt, 6);
    ins(6'b000011, 6'b000000);
    step("jal_f", 0, 1, f_ack);
    step("jal_d", 0, 1, mk(0,0,1,0,1,2'b10,0,2'b10,2'b10,0,3'd0,0));
    ins(6'b000010, 6'b000000);
    step("j_f", 0, 1, f_ack);
    step("j_d", 0, 1, mk(0,0,1,0,0,2'b00,0,2'b00,2'b10,0,3'd0,0));
    ins(6'b000000, 6'b001000);
    step("jr_f", 0, 1, f_ack);
    step("jr_d", 0, 1, mk(0,0,1,0,0,2'b00,0,2'b00,2'b11,0,3'd0,0));
    chk("cnt_jumps", instr_cnt, 9);
    ins(6'b001101, 6'b000000);
    step("ori_f", 0, 1, f_ack);
    step("ori_d", 0, 1, nil);
    step("ori_e", 0, 1, mk(0,0,0,0,0,2'b00,1,2'b00,2'b00,0,3'd2,0));
    step("ori_wb", 0, 1, wb_i);
    ins(6'b001111, 6'b000000);
    step("lui_f", 0, 1, f_ack);
    step("lui_d", 0, 1, nil);
    step("lui_e", 0, 1, mk(0,0,0,0,0,2'b00,1,2'b00,2'b00,0,3'd3,0));
    step("lui_wb", 0, 1, wb_i);
    chk("cnt_imm", instr_cnt, 11);
    ins(6'b000010, 6'b000000);
    for (int i = 0; i < 4; i++) begin
      step("jloop_f", 0, 1, f_ack);
      step("jloop_d", 0, 1, mk(0,0,1,0,0,2'b00,0,2'b00,2'b10,0,3'd0,0));
    end
    chk("cnt4_15", {28'd0, instr_cnt4}, 15);
    step("jwrap_f", 0, 1, f_ack);
    step("jwrap_d", 0, 1, mk(0,0,1,0,0,2'b00,0,2'b00,2'b10,0,3'd0,0));
    chk("cnt4_wrap", {28'd0, instr_cnt4}, 0);
    chk("cnt_16", instr_cnt, 16);
    ins(6'b111111, 6'b000000);
    step("ill_f", 0, 1, f_ack);
    step("ill_d", 0, 1, nil);
`ifdef MC_CTRL_TRAP_EN
    for (int i = 0; i < 3; i++) step("trap_hold", 0, 1, mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,3'd0,1));
    chk("cnt_trap", instr_cnt, 16);
`else
    chk("cnt_nop", instr_cnt, 17);
    step("nop_next_f", 0, 1, f_ack);
`endif
    reset = 1'b1;
    #1;
    chk("async_rst_outs", {15'd0, outs}, 32'd0);
    chk("async_rst_cnt", instr_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ins(6'b000000, 6'b100001);
    step("post_rst_f", 0, 1, f_ack);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
